// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_pkg
//  Description : Shared types and default constants for the OFIFO-to-psum
//                accumulation slice (state encoding, pass geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package psum_pkg;

  localparam int NUM_KIJ  = 9;
  localparam int LEN_ONIJ = 16;

  typedef enum logic [2:0] {
    POP   = 3'd0,
    RD    = 3'd1,
    ACC   = 3'd2,
    WR    = 3'd3,
    KDONE = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Address width for a bank of the given depth; never collapses to zero bits.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofifo_to_psum_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : ofifo_to_psum_fsm_if
//  Description : OFIFO read side and psum bank port bundled together.
//                master = accumulation FSM, slave = OFIFO/bank environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ofifo_to_psum_fsm_if
  import psum_pkg::*;
#(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int len_onij = LEN_ONIJ
);

  localparam int ROW_W = psum_bw * col;
  localparam int AW    = addr_width(len_onij);

  logic             ofifo_valid_i;
  logic [ROW_W-1:0] ofifo_data_i;
  logic             ofifo_rd_o;
  logic             psum_bank_en_n_o;
  logic             psum_bank_wen_n_o;
  logic [AW-1:0]    psum_bank_addr_o;
  logic [ROW_W-1:0] psum_bank_wdata_o;
  logic [ROW_W-1:0] psum_bank_rdata_i;

  modport master (
    input  ofifo_valid_i, ofifo_data_i, psum_bank_rdata_i,
    output ofifo_rd_o, psum_bank_en_n_o, psum_bank_wen_n_o,
           psum_bank_addr_o, psum_bank_wdata_o
  );

  modport slave (
    output ofifo_valid_i, ofifo_data_i, psum_bank_rdata_i,
    input  ofifo_rd_o, psum_bank_en_n_o, psum_bank_wen_n_o,
           psum_bank_addr_o, psum_bank_wdata_o
  );

endinterface
`default_nettype wire

// File: rtl/psum_lane_adder.sv
`default_nettype none
// ============================================================================
//  Module      : psum_lane_adder
//  Description : Lane-wise signed add of two psum rows. Wraps modulo
//                2^psum_bw by default; with PSUM_SAT_EN defined each lane
//                clamps to the signed psum_bw range instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_lane_adder #(
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic [psum_bw*col-1:0] a_i,
  input  logic [psum_bw*col-1:0] b_i,
  output logic [psum_bw*col-1:0] sum_o
);

  for (genvar i = 0; i < col; i++) begin : g_lane
`ifdef PSUM_SAT_EN
    localparam logic [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};
    logic [psum_bw:0] wide;
    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign wide = {a_i[psum_bw*i + psum_bw-1], a_i[psum_bw*i +: psum_bw]}
                + {b_i[psum_bw*i + psum_bw-1], b_i[psum_bw*i +: psum_bw]};
    assign sum_o[psum_bw*i +: psum_bw] =
        (wide[psum_bw] == wide[psum_bw-1]) ? wide[psum_bw-1:0]
      : (wide[psum_bw] ? LANE_MIN : LANE_MAX);
`else
    assign sum_o[psum_bw*i +: psum_bw] = a_i[psum_bw*i +: psum_bw]
                                       + b_i[psum_bw*i +: psum_bw];
`endif
  end : g_lane

endmodule
`default_nettype wire

// File: rtl/ofifo_to_psum_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : ofifo_to_psum_fsm
//  Description : Drains OFIFO rows into the psum bank. Pass 0 writes each row
//                straight to address onij; later passes read back, add the
//                new row lane-wise and write the sum. After num_kij passes the
//                block parks in DONE until reset.
//                Optional macro: PSUM_SAT_EN (saturating lane adds).
//  Revision    : 1.0 - initial release
// ============================================================================
module ofifo_to_psum_fsm
  import psum_pkg::*;
#(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int len_onij = LEN_ONIJ,
  parameter int num_kij  = NUM_KIJ
) (
  input  logic                clk,
  input  logic                reset,
  ofifo_to_psum_fsm_if.master bus,
  output logic [3:0]          kij_index_o,
  output logic                kij_done_o,
  output logic                all_done_o
);

  localparam int              ROW_W     = psum_bw * col;
  localparam int              AW        = addr_width(len_onij);
  localparam logic [AW-1:0]   LAST_ONIJ = AW'(len_onij - 1);
  localparam logic [3:0]      KIJ_END   = 4'(num_kij);

  state_e           state_q, state_d;
  logic [AW-1:0]    onij_q,  onij_d;
  logic [3:0]       kij_q,   kij_d;
  logic [ROW_W-1:0] row_q,   row_d;
  logic [ROW_W-1:0] sum_q,   sum_d;
  logic [ROW_W-1:0] wdata_q, wdata_d;
  logic [ROW_W-1:0] lane_sum;
  logic             rd_w, en_n_w, wen_n_w, kij_done_w, all_done_w;

  psum_lane_adder #(
    .psum_bw (psum_bw),
    .col     (col)
  ) u_lane_adder (
    .a_i   (bus.psum_bank_rdata_i),
    .b_i   (row_q),
    .sum_o (lane_sum)
  );

  // State and datapath registers; synchronous reset abandons any in-flight row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= POP;
      onij_q  <= '0;
      kij_q   <= '0;
      row_q   <= '0;
      sum_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      onij_q  <= onij_d;
      kij_q   <= kij_d;
      row_q   <= row_d;
      sum_q   <= sum_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    state_d    = state_q;
    onij_d     = onij_q;
    kij_d      = kij_q;
    row_d      = row_q;
    sum_d      = sum_q;
    wdata_d    = wdata_q;
    rd_w       = 1'b0;
    en_n_w     = 1'b1;
    wen_n_w    = 1'b1;
    kij_done_w = 1'b0;
    all_done_w = 1'b0;

    case (state_q)
      POP: begin
        rd_w = bus.ofifo_valid_i;
        if (bus.ofifo_valid_i) begin
          row_d   = bus.ofifo_data_i;
          state_d = (kij_q == 4'd0) ? WR : RD;
        end
      end
      RD: begin
        en_n_w  = 1'b0;
        state_d = ACC;
      end
      ACC: begin
        sum_d   = lane_sum;
        state_d = WR;
      end
      WR: begin
        en_n_w  = 1'b0;
        wen_n_w = 1'b0;
        wdata_d = (kij_q == 4'd0) ? row_q : sum_q;
        if (onij_q == LAST_ONIJ) begin
          onij_d  = '0;
          state_d = KDONE;
        end else begin
          onij_d  = onij_q + 1'b1;
          state_d = POP;
        end
      end
      KDONE: begin
        kij_done_w = 1'b1;
        kij_d      = kij_q + 4'd1;
        state_d    = (kij_q + 4'd1 == KIJ_END) ? DONE : POP;
      end
      DONE: begin
        all_done_w = 1'b1;
      end
      default: state_d = POP;
    endcase

    // A reset cycle must never pop or touch the bank.
    if (reset) begin
      rd_w    = 1'b0;
      en_n_w  = 1'b1;
      wen_n_w = 1'b1;
    end
  end

  assign bus.ofifo_rd_o        = rd_w;
  assign bus.psum_bank_en_n_o  = en_n_w;
  assign bus.psum_bank_wen_n_o = wen_n_w;
  assign bus.psum_bank_addr_o  = onij_q;
  assign bus.psum_bank_wdata_o = (state_q == WR) ? wdata_d : wdata_q;
  assign kij_index_o           = kij_q;
  assign kij_done_o            = kij_done_w;
  assign all_done_o            = all_done_w;

endmodule
`default_nettype wire

// File: tb/tb_ofifo_to_psum_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofifo_to_psum_fsm
//  Description : Bench for ofifo_to_psum_fsm: queue-based OFIFO, behavioural
//                bank, and a pass-accumulation reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofifo_to_psum_fsm;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int LEN     = 16;
  localparam int NKIJ    = 9;
  localparam int W       = PSUM_BW * COL;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] kij_index;
  logic       kij_done;
  logic       all_done;

  ofifo_to_psum_fsm_if #(.psum_bw(PSUM_BW), .col(COL), .len_onij(LEN)) bus ();

  ofifo_to_psum_fsm #(
    .psum_bw (PSUM_BW), .col (COL), .len_onij (LEN), .num_kij (NKIJ)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .kij_index_o (kij_index),
    .kij_done_o  (kij_done),
    .all_done_o  (all_done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port bank: read data appears one cycle after request.
  logic [W-1:0] bank_mem [LEN];
  always @(posedge clk) begin
    if (!bus.psum_bank_en_n_o) begin
      if (!bus.psum_bank_wen_n_o) bank_mem[bus.psum_bank_addr_o] <= bus.psum_bank_wdata_o;
      else                        bus.psum_bank_rdata_i <= bank_mem[bus.psum_bank_addr_o];
    end
  end

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] fifo   [$];
  logic [W-1:0] popped [$];
  logic [W-1:0] exp_mem [LEN];
  int           cyc, pops, wr_cnt, kd_cnt, last_wr_cyc, pops_since_wr, ovf_exp;
  bit           check_gap, toggle_mode, found;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    int v;
    for (int i = 0; i < COL; i++) begin
      v = int'($urandom);
      r[i*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
    end
    return r;
  endfunction

  // Signed lane-wise sum in plain integer arithmetic.
  function automatic logic [W-1:0] row_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    int s;
    for (int i = 0; i < COL; i++) begin
      s = int'($signed(a[i*PSUM_BW +: PSUM_BW])) + int'($signed(b[i*PSUM_BW +: PSUM_BW]));
`ifdef PSUM_SAT_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`endif
      r[i*PSUM_BW +: PSUM_BW] = s[PSUM_BW-1:0];
    end
    return r;
  endfunction

  task automatic drive();
    bus.ofifo_valid_i = (fifo.size() > 0) && (!toggle_mode || ((cyc / 3) % 2 == 0));
    bus.ofifo_data_i  = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  // One clock: observe at the falling edge, update stimulus just after rising.
  task automatic step();
    bit           do_pop;
    logic [W-1:0] row, expv;
    int           onij, pass;
    do_pop = 1'b0;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("no_bank_access_in_reset", W'(bus.psum_bank_en_n_o), W'(1));
    end else begin
      if (bus.ofifo_rd_o) begin
        chk("pop_only_when_valid", W'(bus.ofifo_valid_i), W'(1));
        chk("one_pop_per_write", W'(pops_since_wr), W'(0));
        pops_since_wr = 1;
        popped.push_back(bus.ofifo_data_i);
        pops++;
        do_pop = 1'b1;
      end
      if (!bus.psum_bank_en_n_o && !bus.psum_bank_wen_n_o) begin
        onij = wr_cnt % LEN;
        pass = wr_cnt / LEN;
        chk("write_has_row", W'(popped.size() > 0), W'(1));
        row  = (popped.size() > 0) ? popped.pop_front() : '0;
        expv = (pass == 0) ? row : row_add(exp_mem[onij], row);
        chk("wr_addr", W'(bus.psum_bank_addr_o), W'(onij));
        chk("wr_data", bus.psum_bank_wdata_o, expv);
        if (check_gap && onij != 0 && last_wr_cyc >= 0)
          chk("wr_spacing", W'(cyc - last_wr_cyc), W'((pass == 0) ? 2 : 4));
        exp_mem[onij] = expv;
        last_wr_cyc   = cyc;
        wr_cnt++;
        pops_since_wr = 0;
      end
      if (kij_done) kd_cnt++;
    end
    @(posedge clk);
    #1;
    if (do_pop && fifo.size() > 0) void'(fifo.pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo.delete();
    drive();
    step();
    popped.delete();
    pops = 0; wr_cnt = 0; kd_cnt = 0; last_wr_cyc = -1; pops_since_wr = 0;
    toggle_mode = 1'b0; check_gap = 1'b0;
    reset = 1'b0;
    drive();
  endtask

  task automatic wait_kd(input int target, input int budget);
    int n = 0;
    while (kd_cnt < target && n < budget) begin step(); n++; end
    chk("kij_done_reached", W'(kd_cnt >= target), W'(1));
  endtask

  task automatic wait_all_done(input int budget);
    int n = 0;
    while (!all_done && n < budget) begin step(); n++; end
    chk("all_done_reached", W'(all_done), W'(1));
  endtask

  task automatic pass0_test();
    check_gap = 1'b1;
    for (int k = 0; k < LEN; k++) fifo.push_back(splat(k + 1));
    drive();
    wait_kd(1, 100);
    step(); step();
    chk("p0_kij_done_once", W'(kd_cnt), W'(1));
    chk("p0_kij_index", W'(kij_index), W'(1));
    chk("p0_writes", W'(wr_cnt), W'(LEN));
    chk("p0_pops", W'(pops), W'(LEN));
    chk("p0_not_done", W'(all_done), W'(0));
  endtask

  initial begin
    reset = 1'b1; cyc = 0; toggle_mode = 1'b0; check_gap = 1'b0;
    do_reset();

    // Reset state
    chk("rst_rd", W'(bus.ofifo_rd_o), W'(0));
    chk("rst_en_n", W'(bus.psum_bank_en_n_o), W'(1));
    chk("rst_wen_n", W'(bus.psum_bank_wen_n_o), W'(1));
    chk("rst_addr", W'(bus.psum_bank_addr_o), W'(0));
    chk("rst_wdata", bus.psum_bank_wdata_o, W'(0));
    chk("rst_kij_done", W'(kij_done), W'(0));
    chk("rst_all_done", W'(all_done), W'(0));
    chk("rst_kij_index", W'(kij_index), W'(0));

    // Single pass 0 with valid held high
    pass0_test();

    // Full run of all-ones rows
    do_reset();
    check_gap = 1'b1;
    for (int k = 0; k < LEN * NKIJ; k++) fifo.push_back(splat(1));
    drive();
    wait_all_done(1500);
    chk("full_pops", W'(pops), W'(LEN * NKIJ));
    chk("full_kij_index", W'(kij_index), W'(NKIJ));
    chk("full_kij_done_count", W'(kd_cnt), W'(NKIJ));
    for (int i = 0; i < LEN; i++) chk("full_bank_word", bank_mem[i], splat(NKIJ));

    // DONE ignores a valid OFIFO
    for (int k = 0; k < 5; k++) fifo.push_back(splat(3));
    drive();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("done_no_pop", W'(bus.ofifo_rd_o), W'(0));
      chk("done_no_bank", W'(bus.psum_bank_en_n_o), W'(1));
    end
    chk("done_held", W'(all_done), W'(1));
    chk("done_fifo_untouched", W'(fifo.size()), W'(5));

    // Random rows with valid toggling every 3 cycles
    do_reset();
    toggle_mode = 1'b1;
    for (int k = 0; k < LEN * NKIJ; k++) fifo.push_back(rand_row());
    drive();
    wait_all_done(5000);
    chk("tog_pops", W'(pops), W'(LEN * NKIJ));
    chk("tog_fifo_drained", W'(fifo.size()), W'(0));
    for (int i = 0; i < LEN; i++) chk("tog_bank_word", bank_mem[i], exp_mem[i]);

    // Lane overflow at the positive limit
    do_reset();
    for (int k = 0; k < LEN; k++) fifo.push_back(splat(32767));
    for (int k = 0; k < LEN; k++) fifo.push_back(splat(1));
    drive();
    wait_kd(2, 300);
    step();
`ifdef PSUM_SAT_EN
    ovf_exp = 32767;
`else
    ovf_exp = -32768;
`endif
    chk("ovf_word0", bank_mem[0], splat(ovf_exp));
    chk("ovf_word15", bank_mem[LEN-1], splat(ovf_exp));

    // Reset in ACC of pass 3, row 5
    do_reset();
    for (int k = 0; k < LEN * 5; k++) fifo.push_back(rand_row());
    drive();
    found = 1'b0;
    for (int n = 0; n < 800 && !found; n++) begin
      step();
      if (kij_index == 4'd3 && bus.psum_bank_addr_o == 4'd5 &&
          !bus.psum_bank_en_n_o && bus.psum_bank_wen_n_o) found = 1'b1;
    end
    chk("midpass_rd_reached", W'(found), W'(1));
    step();
    chk("midpass_acc_idle_bank", W'(bus.psum_bank_en_n_o), W'(1));
    do_reset();
    chk("midpass_rst_en_n", W'(bus.psum_bank_en_n_o), W'(1));
    chk("midpass_rst_kij_index", W'(kij_index), W'(0));
    chk("midpass_rst_addr", W'(bus.psum_bank_addr_o), W'(0));
    pass0_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
